// File: rtl/spi_mem_bridge_pkg.sv
// Shared definitions for the SPI memory bridge.
// Holds the FSM state encoding, the bit positions of CPOL/CPHA inside the
// SPI mode number, and helpers that extract those bits when the bridge
// is elaborated.
package spi_mem_bridge_pkg;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  function automatic logic mode_cpol(input int mode);
    return ((mode >> CPOL_BIT) & 1) != 0;
  endfunction

  function automatic logic mode_cpha(input int mode);
    return ((mode >> CPHA_BIT) & 1) != 0;
  endfunction

endpackage

// File: rtl/spi_mem_bridge_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, plus rise/fall
// detection on the synchronised value.
// Ports:
//   clk_i   system clock          rst_ni  async reset, active-low
//   d_i     asynchronous pin      q_o     synchronised level
//   rise_o  one-clk 0->1 pulse    fall_o  one-clk 1->0 pulse
// RESET_VAL is the pin's idle level, so leaving reset never produces a
// false edge.
module spi_mem_bridge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] form the synchroniser, [2] is the previous synchronised value.
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {3{RESET_VAL}};
    else         sync_q <= {sync_q[1:0], d_i};
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI slave giving an external host burst read/write access to an on-chip
// memory port. All SPI pins are oversampled in the clk_i domain.
// Ports:
//   clk_i, rst_ni             system clock, async reset (active-low)
//   spi_clk_i, spi_mosi_i     SPI clock and data in (MSB first)
//   spi_ss_i                  slave select, active level SS_ACTIVE
//   spi_miso_o                SPI data out (MSB first)
//   mem_addr_o, mem_dout_o    memory address / write data
//   mem_din_i                 read data, valid 1 clk after mem_rd_o
//   mem_wrt_o, mem_rd_o       one-clk write / read strobes
//
// state    | meaning
// ST_IDLE  | no frame; waiting for select
// ST_CMD   | shifting in the command word
// ST_WRITE | each data word becomes a memory write
// ST_READ  | prefetching memory words and shifting them out on MISO
module spi_mem_bridge
  import spi_mem_bridge_pkg::*;
#(
  parameter int   ADDR_WIDTH = 4,
  parameter int   DATA_WIDTH = 8,
  parameter int   SPI_MODE   = 0,
  parameter logic SS_ACTIVE  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  spi_clk_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  input  logic                  spi_ss_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_din_i,
  output logic [DATA_WIDTH-1:0] mem_dout_o,
  output logic                  mem_wrt_o,
  output logic                  mem_rd_o
);

  localparam logic            CPOL     = mode_cpol(SPI_MODE);
  localparam logic            CPHA     = mode_cpha(SPI_MODE);
  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic clk_s, clk_rise, clk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ss_s, ss_rise, ss_fall;

  spi_mem_bridge_sync #(.RESET_VAL(CPOL)) u_sync_clk (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_clk_i),
    .q_o(clk_s), .rise_o(clk_rise), .fall_o(clk_fall)
  );
  spi_mem_bridge_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_mosi_i),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );
  spi_mem_bridge_sync #(.RESET_VAL(~SS_ACTIVE)) u_sync_ss (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_ss_i),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{clk_s, mosi_rise, mosi_fall, ss_rise, ss_fall};

  logic lead_edge, trail_edge, sample_edge, shift_edge, ss_active;
  assign lead_edge   = CPOL ? clk_fall : clk_rise;
  assign trail_edge  = CPOL ? clk_rise : clk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_active   = (ss_s == SS_ACTIVE);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   rx_q, rx_d, tx_q, tx_d, dout_q, dout_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    miso_q, miso_d, wrt_q, wrt_d, rd_q, rd_d, load_q, load_d;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic                    word_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      dout_q    <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      wrt_q     <= 1'b0;
      rd_q      <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      wrt_q     <= wrt_d;
      rd_q      <= rd_d;
      load_q    <= load_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    dout_d    = dout_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    wrt_d     = 1'b0;
    rd_d      = 1'b0;
    load_d    = rd_q;
    rx_word   = {rx_q[DATA_WIDTH-2:0], mosi_s};
    word_done = 1'b0;

    if (state_q != ST_IDLE && sample_edge) begin
      rx_d      = rx_word;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (bit_cnt_q == LAST_BIT) begin
        word_done = 1'b1;
        bit_cnt_d = '0;
      end
    end

    // With CPHA=0 the shift edge that follows a word's last sample must not
    // shift: the next word is already loaded with its MSB on the pin.
    if (state_q == ST_READ && shift_edge && (CPHA || bit_cnt_q != '0)) begin
      miso_d = tx_q[DATA_WIDTH-1];
      tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
    end

    if (wrt_q) addr_d = addr_q + ADDR_WIDTH'(1);

    // Prefetched read data arrives one clk after the strobe.
    if (load_q && state_q == ST_READ) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (CPHA) begin
        tx_d = mem_din_i;
      end else begin
        tx_d   = {mem_din_i[DATA_WIDTH-2:0], 1'b0};
        miso_d = mem_din_i[DATA_WIDTH-1];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_active) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end
      ST_CMD: begin
        if (word_done) begin
          addr_d = rx_word[ADDR_WIDTH-1:0];
          if (rx_word[DATA_WIDTH-1]) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
            rd_d    = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (word_done) begin
          dout_d = rx_word;
          wrt_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (word_done) rd_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A word finishing in the same clk as deselect is still acted on above.
    if (state_q != ST_IDLE && !ss_active) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end
    if (state_q != ST_READ || !ss_active) miso_d = 1'b0;
  end

  // Raw select gates the pin so MISO drops as soon as the host deselects.
  assign spi_miso_o = miso_q & (spi_ss_i == SS_ACTIVE);
  assign mem_addr_o = addr_q;
  assign mem_dout_o = dout_q;
  assign mem_wrt_o  = wrt_q;
  assign mem_rd_o   = rd_q;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: four instances cover SPI modes 0..3, with
// odd-numbered instances using an active-low select. A memory model per
// instance answers reads one clk after the strobe and applies writes; a
// reference model derives expected memory transactions and MISO words
// from the frame contents alone.
module tb_spi_mem_bridge;

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } txn_t;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] spi_clk, spi_mosi, spi_ss;
  logic       spi_miso [4];
  logic       mem_wrt  [4];
  logic       mem_rd   [4];
  logic [3:0] mem_addr [4];
  logic [7:0] mem_din  [4];
  logic [7:0] mem_dout [4];

  logic [7:0] init_img [4][16];
  logic [7:0] dut_mem  [4][16];
  logic [7:0] ref_mem  [4][16];
  bit         mem_ready = 1'b0;
  txn_t       mon_q [4][$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_mem_bridge #(
      .ADDR_WIDTH(4), .DATA_WIDTH(8), .SPI_MODE(g), .SS_ACTIVE((g % 2) == 0)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .spi_clk_i(spi_clk[g]), .spi_mosi_i(spi_mosi[g]), .spi_miso_o(spi_miso[g]),
      .spi_ss_i(spi_ss[g]),
      .mem_addr_o(mem_addr[g]), .mem_din_i(mem_din[g]), .mem_dout_o(mem_dout[g]),
      .mem_wrt_o(mem_wrt[g]), .mem_rd_o(mem_rd[g])
    );
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4; i++) begin
        mem_din[i] <= 8'h00;
        for (int a = 0; a < 16; a++) dut_mem[i][a] <= init_img[i][a];
      end
      mem_ready <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mem_rd[i])  mem_din[i] <= dut_mem[i][mem_addr[i]];
        if (mem_wrt[i]) dut_mem[i][mem_addr[i]] <= mem_dout[i];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wrt[i] || mem_rd[i]) begin
        check_val($sformatf("i%0d_strobe_excl", i), 32'(mem_wrt[i] & mem_rd[i]), 0);
        mon_q[i].push_back('{wr: mem_wrt[i], addr: mem_addr[i],
                             data: (mem_wrt[i] ? mem_dout[i] : 8'h00)});
      end
    end
  end

  function automatic logic ss_level(input int i, input bit act);
    logic lvl;
    lvl = ((i % 2) == 0);
    return act ? lvl : ~lvl;
  endfunction

  task automatic half_period();
    repeat (HALF) @(negedge clk);
  endtask

  // Expected effects of a frame, given only its complete words.
  task automatic ref_frame(input int i, input logic [7:0] words[$],
                           output txn_t exp_t[$], output logic [7:0] exp_m[$]);
    logic [7:0] cmd;
    int         a, ad;
    exp_t.delete();
    exp_m.delete();
    if (words.size() == 0) return;
    cmd = words[0];
    a   = int'(cmd[3:0]);
    exp_m.push_back(8'h00);
    if (cmd[7]) begin
      for (int k = 1; k < words.size(); k++) begin
        ad = (a + k - 1) % 16;
        exp_t.push_back('{wr: 1'b1, addr: 4'(ad), data: words[k]});
        ref_mem[i][ad] = words[k];
        exp_m.push_back(8'h00);
      end
    end else begin
      for (int k = 0; k < words.size(); k++) begin
        exp_t.push_back('{wr: 1'b0, addr: 4'((a + k) % 16), data: 8'h00});
        if (k > 0) exp_m.push_back(ref_mem[i][(a + k - 1) % 16]);
      end
    end
  endtask

  task automatic spi_xfer(input int i, input logic [7:0] words[$], input int extra,
                          input bit keep_ss, output logic [7:0] got[$]);
    logic       cpol, cpha;
    logic [7:0] r, wd;
    int         nb, nw;
    cpol = (i & 2) != 0;
    cpha = (i & 1) != 0;
    got.delete();
    spi_clk[i] = cpol;
    spi_ss[i]  = ss_level(i, 1'b1);
    half_period();
    nw = words.size() + ((extra > 0) ? 1 : 0);
    for (int w = 0; w < nw; w++) begin
      nb = (w < words.size()) ? 8 : extra;
      wd = (w < words.size()) ? words[w] : 8'($urandom);
      r  = 8'h00;
      for (int b = 0; b < nb; b++) begin
        if (!cpha) begin
          spi_mosi[i] = wd[7-b];
          half_period();
          spi_clk[i] = ~cpol;
          r = {r[6:0], spi_miso[i]};
          half_period();
          spi_clk[i] = cpol;
        end else begin
          spi_clk[i]  = ~cpol;
          spi_mosi[i] = wd[7-b];
          half_period();
          spi_clk[i] = cpol;
          r = {r[6:0], spi_miso[i]};
          half_period();
        end
      end
      if (nb == 8) got.push_back(r);
    end
    half_period();
    if (!keep_ss) begin
      spi_ss[i] = ss_level(i, 1'b0);
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int i, input logic [7:0] words[$], input int extra);
    txn_t       exp_t[$];
    logic [7:0] exp_m[$];
    logic [7:0] got[$];
    ref_frame(i, words, exp_t, exp_m);
    spi_xfer(i, words, extra, 1'b0, got);
    repeat (8) @(negedge clk);
    check_val($sformatf("i%0d_miso_idle", i), 32'(spi_miso[i]), 0);
    check_val($sformatf("i%0d_txn_count", i), mon_q[i].size(), exp_t.size());
    for (int k = 0; k < exp_t.size(); k++)
      if (k < mon_q[i].size())
        check_val($sformatf("i%0d_txn%0d", i, k), 32'(mon_q[i][k]), 32'(exp_t[k]));
    check_val($sformatf("i%0d_miso_words", i), got.size(), exp_m.size());
    for (int k = 0; k < exp_m.size(); k++)
      if (k < got.size())
        check_val($sformatf("i%0d_miso%0d", i, k), 32'(got[k]), 32'(exp_m[k]));
    mon_q[i].delete();
  endtask

  task automatic reset_mid_frame();
    logic [7:0] w[$];
    logic [7:0] got[$];
    w = '{8'h8E};
    spi_xfer(0, w, 4, 1'b1, got);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_addr", 32'(mem_addr[0]), 0);
    check_val("rst_mid_dout", 32'(mem_dout[0]), 0);
    check_val("rst_mid_wrt", 32'(mem_wrt[0]), 0);
    check_val("rst_mid_rd", 32'(mem_rd[0]), 0);
    check_val("rst_mid_miso", 32'(spi_miso[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    spi_ss[0] = ss_level(0, 1'b0);
    repeat (20) @(negedge clk);
    check_val("rst_mid_no_txn", mon_q[0].size(), 0);
    mon_q[0].delete();
  endtask

  initial begin
    logic [7:0] w[$];
    int         n, extra;
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 16; a++) begin
        init_img[i][a] = 8'($urandom);
        ref_mem[i][a]  = init_img[i][a];
      end
    rst_n    = 1'b0;
    spi_clk  = 4'b1100;
    spi_ss   = 4'b1010;
    spi_mosi = 4'b0000;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("i%0d_rst_addr", i), 32'(mem_addr[i]), 0);
      check_val($sformatf("i%0d_rst_dout", i), 32'(mem_dout[i]), 0);
      check_val($sformatf("i%0d_rst_wrt", i), 32'(mem_wrt[i]), 0);
      check_val($sformatf("i%0d_rst_rd", i), 32'(mem_rd[i]), 0);
      check_val($sformatf("i%0d_rst_miso", i), 32'(spi_miso[i]), 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      w = '{8'h8E, 8'hA5, 8'h5A};
      run_frame(i, w, 0);
      if (i == 0) reset_mid_frame();
      w = '{8'h8F, 8'h11, 8'h22};
      run_frame(i, w, 0);
      w = '{8'h0A, 8'($urandom), 8'($urandom)};
      run_frame(i, w, 0);
      w = '{8'h83};
      run_frame(i, w, 4);
      w = '{8'h83, 8'h77};
      run_frame(i, w, 0);
      w = '{8'h0E, 8'($urandom), 8'($urandom), 8'($urandom)};
      run_frame(i, w, 0);
      repeat (6) begin
        n = $urandom_range(0, 3);
        w.delete();
        w.push_back(8'($urandom));
        repeat (n) w.push_back(8'($urandom));
        extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        run_frame(i, w, extra);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
